acc_addr_gen: RTL and testbench

Address/control sequencer feeding `module_acc_1x8`. It counts output-map positions in raster order for each input-channel pass and issues the accumulator's read and write addresses. It generates `read_en`/`write_en`, and `prev_data_zero`/`curr_data_zero` aligned to the accumulator's read-modify-write pipeline. It sits between the 1x8 conv MAC array (which supplies `in_valid` per output vector) and the accumulator buffer. It signals when the final pass has been written.

---
 rtl/acc_pkg.sv | 25 ++
 rtl/acc_delay_line.sv | 40 ++++
 rtl/acc_addr_gen.sv | 180 ++++++++++++++++++
 tb/tb_acc_addr_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator address generator and the
// 1x8 accumulator datapath.
//   - default geometry: output-map positions per pass, address width,
//     pass-count width and accumulator read+add latency
//   - partial-sum width used by module_acc_1x8
//   - sequencer FSM state type
// ---------------------------------------------------------------------------
package acc_pkg;

    localparam int DEPTH_DEF    = 114 * 114;
    localparam int ADDR_BIT_DEF = 14;
    localparam int PASS_BIT_DEF = 8;
    localparam int WR_LAT_DEF   = 2;
    localparam int PSUM_BIT     = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/acc_delay_line.sv
// ---------------------------------------------------------------------------
// acc_delay_line
// Fixed-length register chain that delays a control bundle by STAGES
// clock cycles. A synchronous clear empties every stage at once, so no
// stale entry can emerge after a reset.
// Ports:
//   clk_i   in   1      clock, rising edge
//   rst_i   in   1      synchronous clear, active high
//   data_i  in   WIDTH  bundle entering the chain
//   data_o  out  WIDTH  bundle leaving the chain STAGES cycles later
// ---------------------------------------------------------------------------
module acc_delay_line #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the bundle one stage per cycle; clear drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[STAGES-1];

endmodule

// File: rtl/acc_addr_gen.sv
// ---------------------------------------------------------------------------
// acc_addr_gen
// Address/control sequencer for the 1x8 accumulator buffer. Walks the
// output map in raster order once per input-channel pass, issues the
// accumulator read of each position and, WR_LAT cycles later, the write
// of the same position together with its first-pass/padding/last-pass flags.
// Ports:
//   clk_i             in   1         clock, rising edge
//   rst_i             in   1         synchronous reset, active high
//   start_i           in   1         begin a layer (honoured only in IDLE)
//   num_pass_i        in   PASS_BIT  passes to accumulate, 0 means 1
//   in_valid_i        in   1         MAC array presents a vector
//   in_pad_i          in   1         presented vector is padding
//   read_en_o         out  1         accumulator read strobe
//   read_addr_o       out  ADDR_BIT  position being read
//   write_en_o        out  1         accumulator write strobe
//   write_addr_o      out  ADDR_BIT  position being written
//   prev_data_zero_o  out  1         ignore stored partial sum (first pass)
//   curr_data_zero_o  out  1         ignore incoming data (padding)
//   last_pass_o       out  1         write belongs to the final pass
//   busy_o            out  1         layer in progress (RUN or DRAIN)
//   done_o            out  1         one-cycle pulse after the last write
// ---------------------------------------------------------------------------
module acc_addr_gen
    import acc_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_BIT = ADDR_BIT_DEF,
    parameter int PASS_BIT = PASS_BIT_DEF,
    parameter int WR_LAT   = WR_LAT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [PASS_BIT-1:0] num_pass_i,
    input  logic                in_valid_i,
    input  logic                in_pad_i,
    output logic                read_en_o,
    output logic [ADDR_BIT-1:0] read_addr_o,
    output logic                write_en_o,
    output logic [ADDR_BIT-1:0] write_addr_o,
    output logic                prev_data_zero_o,
    output logic                curr_data_zero_o,
    output logic                last_pass_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int CNT_BIT    = $clog2(WR_LAT + 1);
    localparam int BUNDLE_BIT = ADDR_BIT + 4;

    acc_state_e          state_q,     state_d;
    logic [PASS_BIT-1:0] numPass_q,   numPass_d;
    logic [PASS_BIT-1:0] pass_q,      pass_d;
    logic [ADDR_BIT-1:0] pos_q,       pos_d;
    logic [CNT_BIT-1:0]  drainCnt_q,  drainCnt_d;

    logic                rdEn_q,      rdEn_d;
    logic [ADDR_BIT-1:0] rdAddr_q,    rdAddr_d;
    logic                firstPass_q, firstPass_d;
    logic                pad_q,       pad_d;
    logic                lastPass_q,  lastPass_d;

    logic                isLastPass;
    logic                posAtEnd;
    logic [BUNDLE_BIT-1:0] rdBundle;
    logic [BUNDLE_BIT-1:0] wrBundle;

    assign isLastPass = (pass_q == numPass_q - PASS_BIT'(1));
    assign posAtEnd   = (pos_q == ADDR_BIT'(DEPTH - 1));

    // Sequencer: counts positions and passes while running, then waits for
    // the pipeline to empty. DRAIN lasts WR_LAT+1 cycles because the final
    // beat still sits in the read stage when RUN is left, so DONE lands one
    // cycle after the final write.
    always_comb begin
        state_d     = state_q;
        numPass_d   = numPass_q;
        pass_d      = pass_q;
        pos_d       = pos_q;
        drainCnt_d  = drainCnt_q;
        rdEn_d      = 1'b0;
        rdAddr_d    = '0;
        firstPass_d = 1'b0;
        pad_d       = 1'b0;
        lastPass_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    numPass_d = (num_pass_i == '0) ? PASS_BIT'(1) : num_pass_i;
                    pass_d    = '0;
                    pos_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (in_valid_i) begin
                    rdEn_d      = 1'b1;
                    rdAddr_d    = pos_q;
                    firstPass_d = (pass_q == '0);
                    pad_d       = in_pad_i;
                    lastPass_d  = isLastPass;
                    if (posAtEnd) begin
                        pos_d  = '0;
                        pass_d = pass_q + PASS_BIT'(1);
                        if (isLastPass) begin
                            drainCnt_d = '0;
                            state_d    = DRAIN;
                        end
                    end else begin
                        pos_d = pos_q + ADDR_BIT'(1);
                    end
                end
            end
            DRAIN: begin
                if (drainCnt_q == CNT_BIT'(WR_LAT)) begin
                    state_d = DONE;
                end else begin
                    drainCnt_d = drainCnt_q + CNT_BIT'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and the registered read stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            numPass_q   <= '0;
            pass_q      <= '0;
            pos_q       <= '0;
            drainCnt_q  <= '0;
            rdEn_q      <= 1'b0;
            rdAddr_q    <= '0;
            firstPass_q <= 1'b0;
            pad_q       <= 1'b0;
            lastPass_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            numPass_q   <= numPass_d;
            pass_q      <= pass_d;
            pos_q       <= pos_d;
            drainCnt_q  <= drainCnt_d;
            rdEn_q      <= rdEn_d;
            rdAddr_q    <= rdAddr_d;
            firstPass_q <= firstPass_d;
            pad_q       <= pad_d;
            lastPass_q  <= lastPass_d;
        end
    end

    // The flags are only set alongside rdEn, so bubbles carry all-zero
    // bundles and the write-side flags stay low whenever write_en is low.
    assign rdBundle = {rdEn_q, rdAddr_q, firstPass_q, pad_q, lastPass_q};

    acc_delay_line #(
        .WIDTH  (BUNDLE_BIT),
        .STAGES (WR_LAT)
    ) u_wr_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (rdBundle),
        .data_o (wrBundle)
    );

    assign {write_en_o, write_addr_o, prev_data_zero_o, curr_data_zero_o, last_pass_o} = wrBundle;

    assign read_en_o   = rdEn_q;
    assign read_addr_o = rdAddr_q;
    assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_acc_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_acc_addr_gen
// Directed bench for acc_addr_gen with DEPTH=4, WR_LAT=2. Each step drives
// the inputs, lets one rising edge pass and compares every output against
// a hand-derived expected vector.
// Vector layout: {read_en, read_addr, write_en, write_addr,
//                 prev_data_zero, curr_data_zero, last_pass, busy, done}
// ---------------------------------------------------------------------------
module tb_acc_addr_gen;

    localparam int DEPTH    = 4;
    localparam int ADDR_BIT = 4;
    localparam int PASS_BIT = 8;
    localparam int WR_LAT   = 2;

    localparam logic [14:0] ZERO  = 15'd0;
    localparam logic [14:0] BUSY  = 15'b000000000000010;
    localparam logic [14:0] DONEV = 15'b000000000000001;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [PASS_BIT-1:0] numPass;
    logic                inValid;
    logic                inPad;
    logic                readEn;
    logic [ADDR_BIT-1:0] readAddr;
    logic                writeEn;
    logic [ADDR_BIT-1:0] writeAddr;
    logic                prevDataZero;
    logic                currDataZero;
    logic                lastPass;
    logic                busy;
    logic                done;

    int checks   = 0;
    int failures = 0;

    acc_addr_gen #(
        .DEPTH    (DEPTH),
        .ADDR_BIT (ADDR_BIT),
        .PASS_BIT (PASS_BIT),
        .WR_LAT   (WR_LAT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .num_pass_i       (numPass),
        .in_valid_i       (inValid),
        .in_pad_i         (inPad),
        .read_en_o        (readEn),
        .read_addr_o      (readAddr),
        .write_en_o       (writeEn),
        .write_addr_o     (writeAddr),
        .prev_data_zero_o (prevDataZero),
        .curr_data_zero_o (currDataZero),
        .last_pass_o      (lastPass),
        .busy_o           (busy),
        .done_o           (done)
    );

    always #5 clk = ~clk;

    // Compare one observed vector with its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [14:0] observed, input logic [14:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [14:0] ex(input logic re, input int ra, input logic we, input int wa,
                                       input logic pdz, input logic cdz, input logic lp,
                                       input logic bsy, input logic dn);
        return {re, 4'(ra), we, 4'(wa), pdz, cdz, lp, bsy, dn};
    endfunction

    // Addresses are don't-care while their strobe is low.
    function automatic logic [14:0] observe();
        return {readEn, (readEn ? readAddr : 4'd0), writeEn, (writeEn ? writeAddr : 4'd0),
                prevDataZero, currDataZero, lastPass, busy, done};
    endfunction

    // Expected outputs after beat b of an uninterrupted layer of nPass passes
    // (steps past the last beat are the drain cycles).
    function automatic logic [14:0] expBeat(input int b, input int nPass);
        int   w;
        logic re;
        logic we;
        w  = b - 2;
        re = (b < nPass * DEPTH);
        we = (w >= 0) && (w < nPass * DEPTH);
        if (!we) w = 0;
        return ex(re, (re ? b % DEPTH : 0), we, w % DEPTH,
                  we && ((w / DEPTH) == 0), 1'b0, we && ((w / DEPTH) == nPass - 1), 1'b1, 1'b0);
    endfunction

    // Drive one cycle of inputs and let a rising edge sample them.
    task automatic applyStimulus(input logic r, input logic st, input logic [PASS_BIT-1:0] np,
                                 input logic v, input logic pd);
        rst     = r;
        start   = st;
        numPass = np;
        inValid = v;
        inPad   = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic stepCheck(input string tag, input logic r, input logic st, input logic [PASS_BIT-1:0] np,
                             input logic v, input logic pd, input logic [14:0] e);
        applyStimulus(r, st, np, v, pd);
        checkOutput(tag, observe(), e);
    endtask

    // Full layer with continuous beats, drain, done pulse and return to idle.
    task automatic runStream(input string tag, input int nPass);
        stepCheck({tag, "_start"}, 1'b0, 1'b1, PASS_BIT'(nPass), 1'b0, 1'b0, BUSY);
        for (int b = 0; b < nPass * DEPTH + 2; b++) begin
            stepCheck($sformatf("%s_b%0d", tag, b), 1'b0, 1'b0, '0, (b < nPass * DEPTH), 1'b0, expBeat(b, nPass));
        end
        stepCheck({tag, "_done"}, 1'b0, 1'b0, '0, 1'b0, 1'b0, DONEV);
        stepCheck({tag, "_idle"}, 1'b0, 1'b0, '0, 1'b0, 1'b0, ZERO);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; numPass = '0; inValid = 1'b0; inPad = 1'b0;

        // 1: reset state, idle in_valid ignored
        stepCheck("rst0",  1'b1, 1'b0, 8'd0, 1'b0, 1'b0, ZERO);
        stepCheck("rst1",  1'b1, 1'b0, 8'd0, 1'b1, 1'b0, ZERO);
        stepCheck("idle0", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ZERO);
        stepCheck("idle1", 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, ZERO);
        stepCheck("idle2", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ZERO);

        // 2: single pass, back-to-back beats
        stepCheck("s2_start", 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, BUSY);
        stepCheck("s2_c1",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 0, 0, 0, 0, 0, 0, 1, 0));
        stepCheck("s2_c2",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 1, 0, 0, 0, 0, 0, 1, 0));
        stepCheck("s2_c3",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 2, 1, 0, 1, 0, 1, 1, 0));
        stepCheck("s2_c4",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 3, 1, 1, 1, 0, 1, 1, 0));
        stepCheck("s2_c5",    1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ex(0, 0, 1, 2, 1, 0, 1, 1, 0));
        stepCheck("s2_c6",    1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ex(0, 0, 1, 3, 1, 0, 1, 1, 0));
        stepCheck("s2_done",  1'b0, 1'b0, 8'd0, 1'b0, 1'b0, DONEV);
        stepCheck("s2_idle",  1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ZERO);

        // 3: three passes, 12 beats
        runStream("s3", 3);

        // 4: gapped beats with padding on the second beat
        stepCheck("s4_start", 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, BUSY);
        stepCheck("s4_c1",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 0, 0, 0, 0, 0, 0, 1, 0));
        stepCheck("s4_c2",    1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        stepCheck("s4_c3",    1'b0, 1'b0, 8'd0, 1'b1, 1'b1, ex(1, 1, 1, 0, 1, 0, 1, 1, 0));
        stepCheck("s4_c4",    1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        stepCheck("s4_c5",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 2, 1, 1, 1, 1, 1, 1, 0));
        stepCheck("s4_c6",    1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        stepCheck("s4_c7",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 3, 1, 2, 1, 0, 1, 1, 0));
        stepCheck("s4_c8",    1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        stepCheck("s4_c9",    1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ex(0, 0, 1, 3, 1, 0, 1, 1, 0));
        stepCheck("s4_done",  1'b0, 1'b0, 8'd0, 1'b0, 1'b0, DONEV);
        stepCheck("s4_idle",  1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ZERO);

        // 5: num_pass=0 acts as one pass; start while busy and in_valid in DRAIN ignored
        stepCheck("s5_start", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, BUSY);
        stepCheck("s5_c1",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 0, 0, 0, 0, 0, 0, 1, 0));
        stepCheck("s5_c2",    1'b0, 1'b1, 8'd5, 1'b1, 1'b0, ex(1, 1, 0, 0, 0, 0, 0, 1, 0));
        stepCheck("s5_c3",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 2, 1, 0, 1, 0, 1, 1, 0));
        stepCheck("s5_c4",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ex(1, 3, 1, 1, 1, 0, 1, 1, 0));
        stepCheck("s5_c5",    1'b0, 1'b1, 8'd5, 1'b1, 1'b0, ex(0, 0, 1, 2, 1, 0, 1, 1, 0));
        stepCheck("s5_c6",    1'b0, 1'b1, 8'd5, 1'b1, 1'b0, ex(0, 0, 1, 3, 1, 0, 1, 1, 0));
        stepCheck("s5_done",  1'b0, 1'b1, 8'd5, 1'b1, 1'b0, DONEV);
        stepCheck("s5_idle0", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, ZERO);
        stepCheck("s5_idle1", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ZERO);

        // 6: reset after the write of address 1 in pass 1 of 2, then restart
        stepCheck("s6_start", 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, BUSY);
        for (int b = 0; b < 8; b++) begin
            stepCheck($sformatf("s6_b%0d", b), 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, expBeat(b, 2));
        end
        stepCheck("s6_rst",   1'b1, 1'b0, 8'd0, 1'b0, 1'b0, ZERO);
        stepCheck("s6_post0", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ZERO);
        stepCheck("s6_post1", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ZERO);
        runStream("s6_re", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
